// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads an opcode byte and, for two-byte opcodes
// (bit 3 set), a parameter byte from a synchronous program memory.
module fetch_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmpAddr,
  output logic [ADDR_W-1:0] pAddr,
  input  logic [7:0]        pData,
  output logic [7:0]        nIR,
  output logic              wIR,
  output logic [7:0]        nPar,
  output logic              wPar,
  output logic [ADDR_W-1:0] PC,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbgState
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    F_OP  = 3'd1,
    L_OP  = 3'd2,
    F_PAR = 3'd3,
    L_PAR = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, nextState;
  logic [7:0] irHold, parHold;
  logic [ADDR_W-1:0] pcInc;

  assign pcInc    = PC + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign pAddr    = PC;
  assign dbgState = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      PC      <= '0;
      irHold  <= 8'h00;
      parHold <= 8'h00;
    end else begin
      state <= nextState;
      if (state == IDLE && jmp)
        PC <= jmpAddr;
      else if (state == L_OP || state == L_PAR)
        PC <= pcInc;
      if (wIR)
        irHold <= pData;
      if (wPar)
        parHold <= pData;
    end
  end

  // Byte outputs pass pData through on the load cycle and hold it afterwards.
  always_comb begin
    nextState = state;
    wIR       = 1'b0;
    wPar      = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    nIR       = irHold;
    nPar      = parHold;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!jmp && start)
          nextState = F_OP;
      end
      F_OP:  nextState = L_OP;
      L_OP: begin
        wIR       = 1'b1;
        nIR       = pData;
        nextState = pData[3] ? F_PAR : DONE;
      end
      F_PAR: nextState = L_PAR;
      L_PAR: begin
        wPar      = 1'b1;
        nPar      = pData;
        nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the program address width.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: controller request to fetch the next instruction.
REQ-005 The block SHALL have port jmp, input, 1 bit: load the program counter from jmpAddr.
REQ-006 The block SHALL have port jmpAddr, input, ADDR_W bits: jump target address.
REQ-007 The block SHALL have port pAddr, output, ADDR_W bits: program memory address.
REQ-008 The block SHALL have port pData, input, 8 bits: program memory read data, valid one cycle after pAddr.
REQ-009 The block SHALL have port nIR, output, 8 bits: instruction byte to the instruction register.
REQ-010 The block SHALL have port wIR, output, 1 bit: instruction register write strobe.
REQ-011 The block SHALL have port nPar, output, 8 bits: parameter byte to the parameter register.
REQ-012 The block SHALL have port wPar, output, 1 bit: parameter register write strobe.
REQ-013 The block SHALL have port PC, output, ADDR_W bits: current program counter.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse when the fetch is complete.

Function
REQ-016 The block SHALL implement the states IDLE, F_OP, L_OP, F_PAR, L_PAR and DONE.
REQ-017 The block SHALL drive pAddr = PC combinationally in all states.
REQ-018 In IDLE with start=1 and jmp=0, the block SHALL go to F_OP.
REQ-019 In IDLE with jmp=1, the block SHALL load PC <= jmpAddr and stay in IDLE, ignoring start in that cycle.
REQ-020 The block SHALL ignore jmp and start in every state other than IDLE.
REQ-021 F_OP SHALL last one cycle and go to L_OP.
REQ-022 In L_OP the block SHALL drive nIR = pData and wIR = 1 for exactly one cycle, and SHALL apply PC <= PC+1 at the closing edge.
REQ-023 From L_OP the block SHALL go to F_PAR if pData[3] = 1 (two-byte instruction), otherwise to DONE.
REQ-024 F_PAR SHALL last one cycle, with pAddr presenting the incremented PC, and go to L_PAR.
REQ-025 In L_PAR the block SHALL drive nPar = pData and wPar = 1 for one cycle, apply PC <= PC+1, and go to DONE.
REQ-026 In DONE the block SHALL assert done = 1 for one cycle and return to IDLE.
REQ-027 Latency from start sampled in IDLE to done high SHALL be 3 cycles for one-byte instructions and 5 cycles for two-byte instructions.
REQ-028 PC SHALL wrap modulo 2^ADDR_W (for ADDR_W = 8: 8'hFF+1 = 8'h00, including mid-instruction).
REQ-029 wIR and wPar SHALL never be high in the same cycle, and neither SHALL be high outside L_OP and L_PAR respectively.
REQ-030 When wIR = 0, nIR SHALL hold its last written value; when wPar = 0, nPar SHALL hold its last written value.

Reset
REQ-031 While rst_n = 0, the block SHALL asynchronously force state = IDLE, PC = 0, nIR = 8'h00, nPar = 8'h00, and wIR = wPar = done = busy = 0.
REQ-032 Reset asserted mid-fetch SHALL abort the fetch with no further write strobes, and the first fetch after reset release SHALL start at address 0.

Verification
REQ-033 The bench SHALL cover: rom[0] = 8'h20, pulse start -> wIR high in cycle 2 with nIR = 8'h20, no wPar, done in cycle 3, PC = 1.
REQ-034 The bench SHALL cover: rom[1] = 8'h38, rom[2] = 8'h05, start -> wIR with nIR = 8'h38, then wPar with nPar = 8'h05 two cycles later, done in cycle 5, PC = 3.
REQ-035 The bench SHALL cover: jmp = 1 with jmpAddr = 8'h40 in IDLE (start also high) -> PC = 8'h40, no fetch; the next start fetches rom[8'h40].
REQ-036 The bench SHALL cover: PC = 8'hFF with rom[8'hFF] = 8'h08 and rom[0] = 8'h11 -> nIR = 8'h08, nPar = 8'h11, final PC = 8'h01.
REQ-037 The bench SHALL cover: rst_n low during F_PAR -> outputs reset immediately, wPar never pulses, and the next start fetches rom[0].
REQ-038 The bench SHALL cover: start or jmp pulsed while busy = 1 -> no effect on PC, state sequence or strobes.
